// File: rtl/rename_regfile_pkg.sv
// Shared widths and encodings for the rename register file.
// These are the defaults of the module parameters: data width, register
// index width, ROB tag width and the "no pending producer" tag value.
package rename_regfile_pkg;
  localparam int unsigned   DATA_W_DEF   = 32;
  localparam int unsigned   REG_W_DEF    = 5;
  localparam int unsigned   TAG_W_DEF    = 4;
  localparam logic [3:0]    TAG_FREE_DEF = 4'b1000;
endpackage

// File: rtl/rename_regfile_read_port.sv
// regfile_read_port: one combinational source-operand read.
// Register 0 always reads as data 0 / TAG_FREE. A same-cycle commit to the
// addressed register forwards its data, and frees the tag only when the
// committing tag is still the stored (youngest) producer.
// Ports:
//   rd_addr_i   register index to read
//   data_arr_i  full data array state
//   tag_arr_i   full tag array state
//   com_*_i     commit port from the ROB (bypass source)
//   rd_data_o   operand value
//   rd_tag_o    pending producer tag, TAG_FREE when value is ready
module regfile_read_port
  import rename_regfile_pkg::*;
#(
  parameter int unsigned        DATA_W   = DATA_W_DEF,
  parameter int unsigned        REG_W    = REG_W_DEF,
  parameter int unsigned        TAG_W    = TAG_W_DEF,
  parameter logic [TAG_W-1:0]   TAG_FREE = TAG_FREE_DEF
) (
  input  logic [REG_W-1:0]                     rd_addr_i,
  input  logic [2**REG_W-1:0][DATA_W-1:0]      data_arr_i,
  input  logic [2**REG_W-1:0][TAG_W-1:0]       tag_arr_i,
  input  logic                                 com_en_i,
  input  logic [REG_W-1:0]                     com_addr_i,
  input  logic [DATA_W-1:0]                    com_data_i,
  input  logic [TAG_W-1:0]                     com_tag_i,
  output logic [DATA_W-1:0]                    rd_data_o,
  output logic [TAG_W-1:0]                     rd_tag_o
);
  logic [TAG_W-1:0] stored_tag;

  always_comb begin
    stored_tag = tag_arr_i[rd_addr_i];
    rd_data_o  = data_arr_i[rd_addr_i];
    rd_tag_o   = stored_tag;
    if (rd_addr_i == '0) begin
      rd_data_o = '0;
      rd_tag_o  = TAG_FREE;
    end else if (com_en_i && (com_addr_i == rd_addr_i)) begin
      rd_data_o = com_data_i;
      // A younger rename keeps ownership; only the matching producer frees it.
      if (stored_tag == com_tag_i) rd_tag_o = TAG_FREE;
    end
  end
endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file plus per-register rename tag.
// Commits from the ROB write data and release the tag if the committing
// entry is still the youngest producer; renames from decode record the new
// producer tag; flush frees every tag. Reads are combinational with a
// commit bypass; a same-cycle rename is not visible to reads.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rs1_*/rs2_*              two decode read ports (addr in, data/tag out)
//   rename_en/addr/tag       destination rename from decode
//   com_en/addr/data/tag     commit from ROB head
//   flush                    discard all speculative renames
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int unsigned        DATA_W   = DATA_W_DEF,
  parameter int unsigned        REG_W    = REG_W_DEF,
  parameter int unsigned        TAG_W    = TAG_W_DEF,
  parameter logic [TAG_W-1:0]   TAG_FREE = TAG_FREE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  rs1_addr,
  input  logic [REG_W-1:0]  rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [DATA_W-1:0] rs2_data,
  output logic [TAG_W-1:0]  rs2_tag,
  input  logic              rename_en,
  input  logic [REG_W-1:0]  rename_addr,
  input  logic [TAG_W-1:0]  rename_tag,
  input  logic              com_en,
  input  logic [REG_W-1:0]  com_addr,
  input  logic [DATA_W-1:0] com_data,
  input  logic [TAG_W-1:0]  com_tag,
  input  logic              flush
);
  localparam int unsigned NREG   = 2**REG_W;
  localparam int unsigned NPORTS = 2;

  logic [NREG-1:0][DATA_W-1:0] data_q, data_d;
  logic [NREG-1:0][TAG_W-1:0]  tag_q,  tag_d;

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (com_en && (com_addr != '0)) begin
      data_d[com_addr] = com_data;
      if (tag_q[com_addr] == com_tag) tag_d[com_addr] = TAG_FREE;
    end
    // Rename after commit so a same-cycle rename of the same register wins.
    if (rename_en && (rename_addr != '0)) tag_d[rename_addr] = rename_tag;
    // Flush overrides any rename; commit data above is kept.
    if (flush) begin
      for (int r = 0; r < int'(NREG); r++) tag_d[r] = TAG_FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      tag_q  <= {NREG{TAG_FREE}};
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  logic [NPORTS-1:0][REG_W-1:0]  rd_addr;
  logic [NPORTS-1:0][DATA_W-1:0] rd_data;
  logic [NPORTS-1:0][TAG_W-1:0]  rd_tag;

  assign rd_addr = {rs2_addr, rs1_addr};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .REG_W   (REG_W),
      .TAG_W   (TAG_W),
      .TAG_FREE(TAG_FREE)
    ) u_rd (
      .rd_addr_i (rd_addr[p]),
      .data_arr_i(data_q),
      .tag_arr_i (tag_q),
      .com_en_i  (com_en),
      .com_addr_i(com_addr),
      .com_data_i(com_data),
      .com_tag_i (com_tag),
      .rd_data_o (rd_data[p]),
      .rd_tag_o  (rd_tag[p])
    );
  end

  assign rs1_data = rd_data[0];
  assign rs1_tag  = rd_tag[0];
  assign rs2_data = rd_data[1];
  assign rs2_tag  = rd_tag[1];
endmodule

// File: tb/tb_rename_regfile.sv
module tb_rename_regfile;
  localparam logic [3:0] TF = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        rename_en;
  logic [4:0]  rename_addr;
  logic [3:0]  rename_tag;
  logic        com_en;
  logic [4:0]  com_addr;
  logic [31:0] com_data;
  logic [3:0]  com_tag;
  logic        flush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rename_regfile dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs1_tag(rs1_tag),
    .rs2_data(rs2_data), .rs2_tag(rs2_tag),
    .rename_en(rename_en), .rename_addr(rename_addr), .rename_tag(rename_tag),
    .com_en(com_en), .com_addr(com_addr), .com_data(com_data), .com_tag(com_tag),
    .flush(flush)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; rename_en = 0; com_en = 0; flush = 0;
    rename_addr = 0; rename_tag = 0; com_addr = 0; com_data = 0; com_tag = 0;
  endtask

  initial begin
    idle();
    rs1_addr = 0; rs2_addr = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;

    // 1. reset state, both ports
    for (int r = 1; r < 32; r++) begin
      rs1_addr = 5'(r); rs2_addr = 5'(32 - r);
      #1;
      chk($sformatf("rst_d1_r%0d", r), rs1_data, 32'h0);
      chk($sformatf("rst_t1_r%0d", r), {28'h0, rs1_tag}, {28'h0, TF});
      chk($sformatf("rst_t2_r%0d", 32 - r), {28'h0, rs2_tag}, {28'h0, TF});
    end

    // 2. rename r5->3, commit with bypass
    rename_en = 1; rename_addr = 5; rename_tag = 3;
    rs1_addr = 5; #1;
    chk("t2_rename_invisible", {28'h0, rs1_tag}, {28'h0, TF});
    tick();
    idle(); #1;
    chk("t2_tag3", {28'h0, rs1_tag}, 32'h3);
    chk("t2_data0", rs1_data, 32'h0);
    com_en = 1; com_addr = 5; com_data = 32'hDEADBEEF; com_tag = 3; #1;
    chk("t2_byp_data", rs1_data, 32'hDEADBEEF);
    chk("t2_byp_tag", {28'h0, rs1_tag}, {28'h0, TF});
    tick();
    idle(); #1;
    chk("t2_st_data", rs1_data, 32'hDEADBEEF);
    chk("t2_st_tag", {28'h0, rs1_tag}, {28'h0, TF});

    // 3. younger producer keeps ownership
    rename_en = 1; rename_addr = 7; rename_tag = 2; tick();
    rename_tag = 6; tick();
    idle();
    rs2_addr = 7;
    com_en = 1; com_addr = 7; com_data = 32'h11; com_tag = 2; #1;
    chk("t3_byp_data", rs2_data, 32'h11);
    chk("t3_byp_tag_kept", {28'h0, rs2_tag}, 32'h6);
    tick();
    idle(); #1;
    chk("t3_data11", rs2_data, 32'h11);
    chk("t3_tag6", {28'h0, rs2_tag}, 32'h6);
    com_en = 1; com_addr = 7; com_data = 32'h22; com_tag = 6; tick();
    idle(); #1;
    chk("t3_data22", rs2_data, 32'h22);
    chk("t3_tagfree", {28'h0, rs2_tag}, {28'h0, TF});

    // 4. same-cycle rename and commit on r9
    rename_en = 1; rename_addr = 9; rename_tag = 1; tick();
    idle();
    rs1_addr = 9;
    rename_en = 1; rename_addr = 9; rename_tag = 4;
    com_en = 1; com_addr = 9; com_data = 32'h55; com_tag = 1; #1;
    chk("t4_byp_data", rs1_data, 32'h55);
    chk("t4_byp_tag", {28'h0, rs1_tag}, {28'h0, TF});
    tick();
    idle(); #1;
    chk("t4_tag4", {28'h0, rs1_tag}, 32'h4);
    chk("t4_data55", rs1_data, 32'h55);

    // 5. register 0 ignores rename and commit
    rename_en = 1; rename_addr = 0; rename_tag = 5; tick();
    idle();
    rs1_addr = 0;
    com_en = 1; com_addr = 0; com_data = 32'hFF; com_tag = 5; #1;
    chk("t5_byp_r0_data", rs1_data, 32'h0);
    tick();
    idle(); #1;
    chk("t5_r0_data", rs1_data, 32'h0);
    chk("t5_r0_tag", {28'h0, rs1_tag}, {28'h0, TF});

    // 6. flush beats same-cycle rename; commit data still lands
    rename_en = 1; rename_addr = 3; rename_tag = 1; tick();
    rename_addr = 4; rename_tag = 2; tick();
    idle();
    rs1_addr = 3; rs2_addr = 4; #1;
    chk("t6_r3_tag1", {28'h0, rs1_tag}, 32'h1);
    chk("t6_r4_tag2", {28'h0, rs2_tag}, 32'h2);
    flush = 1; rename_en = 1; rename_addr = 6; rename_tag = 7;
    com_en = 1; com_addr = 3; com_data = 32'h33; com_tag = 0;
    tick();
    idle(); #1;
    chk("t6_r3_free", {28'h0, rs1_tag}, {28'h0, TF});
    chk("t6_r4_free", {28'h0, rs2_tag}, {28'h0, TF});
    chk("t6_r3_data", rs1_data, 32'h33);
    rs1_addr = 6; #1;
    chk("t6_r6_free", {28'h0, rs1_tag}, {28'h0, TF});

    // reset has priority over a same-cycle rename and commit
    rename_en = 1; rename_addr = 12; rename_tag = 2; tick();
    idle();
    rst = 1; rename_en = 1; rename_addr = 10; rename_tag = 3;
    com_en = 1; com_addr = 11; com_data = 32'h77; com_tag = 0;
    tick();
    idle(); #1;
    rs1_addr = 5; rs2_addr = 7; #1;
    chk("rst_r5_data", rs1_data, 32'h0);
    chk("rst_r7_data", rs2_data, 32'h0);
    rs1_addr = 9; rs2_addr = 3; #1;
    chk("rst_r9_data", rs1_data, 32'h0);
    chk("rst_r3_data", rs2_data, 32'h0);
    rs1_addr = 10; rs2_addr = 11; #1;
    chk("rst_r10_tag", {28'h0, rs1_tag}, {28'h0, TF});
    chk("rst_r11_data", rs2_data, 32'h0);
    rs1_addr = 12; #1;
    chk("rst_r12_tag", {28'h0, rs1_tag}, {28'h0, TF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
